// File: rtl/irq_pkg.sv
// Shared widths and FSM state type for the interrupt pending controller.
package irq_pkg;
   localparam int NUM_IRQ = 4;
   localparam int ID_W    = 2;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;
endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Presentation handshake between the controller (master) and its consumer.
interface irq_pending_ctrl_if;
   import irq_pkg::*;

   logic            irq_valid;
   logic [ID_W-1:0] irq_id;
   logic            irq_ready;

   modport master (output irq_valid, output irq_id, input irq_ready);
   modport slave  (input irq_valid, input irq_id, output irq_ready);
endinterface

// File: rtl/priority_encoder_4to2.sv
// Strict-priority encoder: highest set input index wins.
module priority_encoder_4to2 (
   input  logic [3:0] in,
   output logic [1:0] out,
   output logic       valid
);
   // Pick the highest asserted line; out is 0 when nothing is set.
   always_comb begin
      valid = |in;
      out   = 2'd0;
      if (in[3])      out = 2'd3;
      else if (in[2]) out = 2'd2;
      else if (in[1]) out = 2'd1;
      else            out = 2'd0;
   end
endmodule

// File: rtl/irq_pending_ctrl.sv
// Latches rising edges of level IRQ lines, presents the highest-priority
// unmasked pending line over a valid/ready handshake, and flags lost edges.
module irq_pending_ctrl
   import irq_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [NUM_IRQ-1:0] mask,
   input  logic               ovf_clr,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] overflow,
   irq_pending_ctrl_if.master irq_bus
);
   state_t             state, state_nxt;
   logic               valid_q, valid_nxt;
   logic [ID_W-1:0]    id_q, id_nxt;
   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] rise, clr, elig;
   logic [ID_W-1:0]    enc_id;
   logic               enc_valid;
   logic               hs;

   assign rise = irq_in & ~irq_prev;
   assign hs   = valid_q & irq_bus.irq_ready;
   assign elig = pending & mask;

   assign irq_bus.irq_valid = valid_q;
   assign irq_bus.irq_id    = id_q;

   // One-hot clear of the line being accepted this cycle.
   always_comb begin
      clr = '0;
      if (hs) clr[id_q] = 1'b1;
   end

   priority_encoder_4to2 u_enc (
      .in    (elig),
      .out   (enc_id),
      .valid (enc_valid)
   );

   // Edge history, pending latch and sticky overflow. A rise that coincides
   // with the clear of the same line re-arms it rather than overflowing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_prev <= '0;
         pending  <= '0;
         overflow <= '0;
      end else begin
         irq_prev <= irq_in;
         pending  <= (pending & ~clr) | rise;
         overflow <= (overflow & {NUM_IRQ{~ovf_clr}}) | (rise & pending & ~clr);
      end
   end

   // Presentation FSM state and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         valid_q <= 1'b0;
         id_q    <= '0;
      end else begin
         state   <= state_nxt;
         valid_q <= valid_nxt;
         id_q    <= id_nxt;
      end
   end

   // Next-state: IDLE loads the encoded id when something is eligible;
   // PRESENT freezes id/valid until the consumer accepts.
   always_comb begin
      state_nxt = state;
      valid_nxt = valid_q;
      id_nxt    = id_q;
      case (state)
         IDLE: begin
            valid_nxt = 1'b0;
            if (enc_valid) begin
               state_nxt = PRESENT;
               valid_nxt = 1'b1;
               id_nxt    = enc_id;
            end
         end
         PRESENT: begin
            if (irq_bus.irq_ready) begin
               state_nxt = IDLE;
               valid_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: a cycle model checked every cycle plus
// hand-computed literal expectations along each scenario.
module tb_irq_pending_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] irq_in, mask;
   logic       ovf_clr;
   logic [3:0] pending, overflow;
   logic       cmp_en;

   int n_chk  = 0;
   int n_fail = 0;

   irq_pending_ctrl_if bus ();

   irq_pending_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .irq_in   (irq_in),
      .mask     (mask),
      .ovf_clr  (ovf_clr),
      .pending  (pending),
      .overflow (overflow),
      .irq_bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model state.
   logic [3:0] m_prev, m_pend, m_ovf;
   logic       m_valid;
   logic [1:0] m_id;

   // Behavioural model: walk each line by its rules, then choose what to show.
   always @(posedge clk or negedge rst_n) begin
      logic [3:0] np, no;
      logic       nv, taken, hs;
      logic [1:0] ni;
      if (!rst_n) begin
         m_prev <= '0; m_pend <= '0; m_ovf <= '0; m_valid <= 1'b0; m_id <= '0;
      end else begin
         hs = m_valid && bus.irq_ready;
         np = m_pend;
         no = ovf_clr ? 4'b0000 : m_ovf;
         for (int i = 0; i < 4; i++) begin
            taken = hs && (m_id == i);
            if (irq_in[i] && !m_prev[i]) begin
               if (m_pend[i] && !taken) no[i] = 1'b1;
               np[i] = 1'b1;
            end else if (taken) begin
               np[i] = 1'b0;
            end
         end
         nv = m_valid;
         ni = m_id;
         if (m_valid) begin
            if (bus.irq_ready) nv = 1'b0;
         end else begin
            for (int i = 3; i >= 0; i--)
               if (m_pend[i] && mask[i] && !nv) begin
                  nv = 1'b1;
                  ni = i[1:0];
               end
         end
         m_prev  <= irq_in;
         m_pend  <= np;
         m_ovf   <= no;
         m_valid <= nv;
         m_id    <= ni;
      end
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         chk("m_valid", {3'b0, bus.irq_valid}, {3'b0, m_valid});
         chk("m_id", {2'b0, bus.irq_id}, {2'b0, m_id});
         chk("m_pending", pending, m_pend);
         chk("m_overflow", overflow, m_ovf);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_vid(input string name, input logic v, input logic [1:0] id);
      chk({name, "_valid"}, {3'b0, bus.irq_valid}, {3'b0, v});
      if (v) chk({name, "_id"}, {2'b0, bus.irq_id}, {2'b0, id});
   endtask

   initial begin
      logic [5:0] exp_v;
      logic [1:0] exp_id [6];
      rst_n = 1'b0; irq_in = '0; mask = 4'hF; ovf_clr = 1'b0;
      bus.irq_ready = 1'b0; cmp_en = 1'b0;

      // Reset state
      tick();
      chk_vid("rst", 1'b0, 2'd0);
      chk("rst_id", {2'b0, bus.irq_id}, 4'd0);
      chk("rst_pend", pending, 4'b0000);
      chk("rst_ovf", overflow, 4'b0000);
      rst_n = 1'b1; cmp_en = 1'b1;
      tick();

      // Single pulse on line 2, ready held high
      bus.irq_ready = 1'b1; irq_in = 4'b0100;
      tick(); chk("p_pend", pending, 4'b0100); chk_vid("p0", 1'b0, 2'd0);
      irq_in = 4'b0000;
      tick(); chk_vid("p1", 1'b1, 2'd2);
      tick(); chk_vid("p2", 1'b0, 2'd0); chk("p_pend_clr", pending, 4'b0000);

      // Simultaneous 1011: order 3, 1, 0 with an idle cycle between
      irq_in = 4'b1011;
      tick(); chk("s_pend", pending, 4'b1011);
      exp_v = 6'b010101;
      exp_id[0] = 2'd3; exp_id[1] = 2'd0; exp_id[2] = 2'd1;
      exp_id[3] = 2'd0; exp_id[4] = 2'd0; exp_id[5] = 2'd0;
      for (int k = 0; k < 6; k++) begin
         tick(); chk_vid("seq", exp_v[k], exp_id[k]);
      end
      chk("s_pend_clr", pending, 4'b0000);
      irq_in = 4'b0000;
      tick();

      // Masked line held pending, then unmasked
      mask = 4'b1101; irq_in = 4'b0010;
      tick(); chk("m_pend0", pending, 4'b0010); chk_vid("msk0", 1'b0, 2'd0);
      for (int k = 0; k < 3; k++) begin
         tick(); chk_vid("msk_hold", 1'b0, 2'd0);
      end
      mask = 4'hF;
      tick(); chk_vid("unmsk", 1'b1, 2'd1);
      tick(); chk_vid("unmsk_done", 1'b0, 2'd0); chk("unmsk_pend", pending, 4'b0000);
      irq_in = 4'b0000;

      // Stall on id 0, higher line arrives mid-presentation
      bus.irq_ready = 1'b0; irq_in = 4'b0001;
      tick(); chk("st_pend", pending, 4'b0001);
      tick(); chk_vid("st0", 1'b1, 2'd0);
      for (int k = 0; k < 5; k++) begin
         tick(); chk_vid("st_hold", 1'b1, 2'd0);
      end
      irq_in = 4'b1001;
      tick(); chk("st_pend2", pending, 4'b1001);
      tick(); chk_vid("st_stable", 1'b1, 2'd0);
      bus.irq_ready = 1'b1;
      tick(); chk_vid("st_acc", 1'b0, 2'd0); chk("st_pend3", pending, 4'b1000);
      tick(); chk_vid("st_next", 1'b1, 2'd3);
      tick(); chk_vid("st_done", 1'b0, 2'd0);
      irq_in = 4'b0000; bus.irq_ready = 1'b0;
      tick();

      // Overflow on line 2, clear, and set-wins-over-clear
      irq_in = 4'b0100;
      tick(); chk("o_pend", pending, 4'b0100);
      tick(); chk_vid("o_pres", 1'b1, 2'd2);
      irq_in = 4'b0000;
      tick();
      irq_in = 4'b0100;
      tick(); chk("o_set", overflow, 4'b0100);
      irq_in = 4'b0000;
      tick();
      irq_in = 4'b0100; ovf_clr = 1'b1;
      tick(); chk("o_setwins", overflow, 4'b0100);
      irq_in = 4'b0000; ovf_clr = 1'b0;
      tick(); chk("o_sticky", overflow, 4'b0100);
      ovf_clr = 1'b1;
      tick(); chk("o_clr", overflow, 4'b0000);
      ovf_clr = 1'b0;
      // Rise coinciding with acceptance of the same line
      irq_in = 4'b0100; bus.irq_ready = 1'b1;
      tick(); chk("rc_pend", pending, 4'b0100); chk("rc_ovf", overflow, 4'b0000);
      chk_vid("rc_idle", 1'b0, 2'd0);
      tick(); chk_vid("rc_repres", 1'b1, 2'd2);
      tick(); chk("rc_pend_clr", pending, 4'b0000);
      irq_in = 4'b0000; bus.irq_ready = 1'b0;
      tick();

      // Asynchronous reset mid-presentation
      irq_in = 4'b1010;
      tick(); chk("r_pend", pending, 4'b1010);
      tick(); chk_vid("r_pres", 1'b1, 2'd3);
      #2 rst_n = 1'b0;
      #1;
      chk_vid("r_async", 1'b0, 2'd0);
      chk("r_async_id", {2'b0, bus.irq_id}, 4'd0);
      chk("r_async_pend", pending, 4'b0000);
      chk("r_async_ovf", overflow, 4'b0000);
      irq_in = 4'b0001;
      tick();
      rst_n = 1'b1;
      tick(); chk("r_first_edge", pending, 4'b0001);
      tick(); chk_vid("r_pres0", 1'b1, 2'd0);
      bus.irq_ready = 1'b1;
      tick(); chk_vid("r_done", 1'b0, 2'd0); chk("r_pend_clr", pending, 4'b0000);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
